// File: rtl/fp_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : fp_accumulator
// Description : Multi-cycle IEEE-754 single-precision accumulator
//               (IDLE/ALIGN/ADD/NORM/DONE), truncating rounding.
//               Define FP_ACC_SATURATE_EN to saturate on overflow instead of
//               producing infinity.
// Revision    : 1.0 - initial release
// ============================================================================
module fp_accumulator #(
    parameter logic [31:0] ACC_INIT = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic        clear,
    output logic [31:0] acc_out,
    output logic        acc_valid,
    output logic        busy,
    output logic [15:0] count
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ALIGN = 3'd1;
    localparam logic [2:0] S_ADD   = 3'd2;
    localparam logic [2:0] S_NORM  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;
    localparam logic [7:0] c_max_shift = 8'd27;

    logic [2:0]  r_state, w_next_state;
    logic [31:0] r_op, r_acc;
    logic [15:0] r_count;
    logic [26:0] r_big_mant, r_small_mant;
    logic        r_big_sign, r_small_sign;
    logic [9:0]  r_exp;
    logic [27:0] r_sum;
    logic        r_sign;
    logic        w_accept;

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next_state = S_ALIGN;
            S_ALIGN: w_next_state = S_ADD;
            S_ADD:   w_next_state = S_NORM;
            S_NORM:  w_next_state = S_DONE;
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
        if (clear) w_next_state = S_IDLE;
    end

    always_comb begin
        in_ready  = (r_state == S_IDLE);
        busy      = (r_state != S_IDLE);
        acc_valid = (r_state == S_DONE);
    end

    assign w_accept = in_valid & in_ready & ~clear;

    // ---------------- ALIGN ----------------
    logic [7:0]  w_acc_exp, w_op_exp, w_diff;
    logic [23:0] w_acc_mant, w_op_mant;
    logic        w_op_big;
    logic [26:0] w_small_ext;

    always_comb begin
        w_acc_exp   = (r_acc[30:23] == 8'd0) ? 8'd1 : r_acc[30:23];
        w_op_exp    = (r_op[30:23]  == 8'd0) ? 8'd1 : r_op[30:23];
        w_acc_mant  = {|r_acc[30:23], r_acc[22:0]};
        w_op_mant   = {|r_op[30:23],  r_op[22:0]};
        w_op_big    = (w_op_exp > w_acc_exp);
        w_diff      = w_op_big ? (w_op_exp - w_acc_exp) : (w_acc_exp - w_op_exp);
        w_small_ext = w_op_big ? {w_acc_mant, 3'b000} : {w_op_mant, 3'b000};
        if (w_diff >= c_max_shift) w_small_ext = 27'd0;
        else                       w_small_ext = w_small_ext >> w_diff;
    end

    // ---------------- ADD ----------------
    logic [27:0] w_add_sum;
    logic        w_add_sign;

    always_comb begin
        if (r_big_sign == r_small_sign) begin
            w_add_sum  = {1'b0, r_big_mant} + {1'b0, r_small_mant};
            w_add_sign = r_big_sign;
        end else if (r_big_mant >= r_small_mant) begin
            w_add_sum  = {1'b0, r_big_mant} - {1'b0, r_small_mant};
            w_add_sign = r_big_sign;
        end else begin
            w_add_sum  = {1'b0, r_small_mant} - {1'b0, r_big_mant};
            w_add_sign = r_small_sign;
        end
        if (w_add_sum == 28'd0) w_add_sign = 1'b0;
    end

    // ---------------- NORM ----------------
    logic [4:0]  w_lz, w_shift;
    logic [9:0]  w_exp_m1, w_norm_exp;
    logic [26:0] w_norm_mant;
    logic [31:0] w_result;
    logic        w_unused_guard;

    always_comb begin
        w_lz = 5'd27;
        for (int i = 0; i < 27; i++) begin
            if (r_sum[i]) w_lz = 5'(26 - i);
        end
        w_exp_m1 = r_exp - 10'd1;
        // Left shift is capped so the exponent never goes below 1 (denormal floor)
        w_shift  = ({5'd0, w_lz} > w_exp_m1) ? w_exp_m1[4:0] : w_lz;
        if (r_sum[27]) begin
            w_norm_mant = r_sum[27:1];
            w_norm_exp  = r_exp + 10'd1;
        end else begin
            w_norm_mant = r_sum[26:0] << w_shift;
            w_norm_exp  = r_exp - {5'd0, w_shift};
        end
        if (!w_norm_mant[26]) w_norm_exp = 10'd0;
        if (w_norm_exp >= 10'd255) begin
`ifdef FP_ACC_SATURATE_EN
            w_result = {r_sign, 8'hFE, 23'h7FFFFF};
`else
            w_result = {r_sign, 8'hFF, 23'h000000};
`endif
        end else begin
            w_result = {r_sign, w_norm_exp[7:0], w_norm_mant[25:3]};
        end
    end

    assign w_unused_guard = ^w_norm_mant[2:0];

    // ---------------- Datapath registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc        <= ACC_INIT;
            r_count      <= 16'd0;
            r_op         <= 32'd0;
            r_big_mant   <= 27'd0;
            r_small_mant <= 27'd0;
            r_big_sign   <= 1'b0;
            r_small_sign <= 1'b0;
            r_exp        <= 10'd0;
            r_sum        <= 28'd0;
            r_sign       <= 1'b0;
        end else if (clear) begin
            r_acc   <= ACC_INIT;
            r_count <= 16'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op    <= in_data;
                        r_count <= r_count + 16'd1;
                    end
                end
                S_ALIGN: begin
                    r_big_mant   <= w_op_big ? {w_op_mant, 3'b000} : {w_acc_mant, 3'b000};
                    r_small_mant <= w_small_ext;
                    r_big_sign   <= w_op_big ? r_op[31] : r_acc[31];
                    r_small_sign <= w_op_big ? r_acc[31] : r_op[31];
                    r_exp        <= {2'b00, (w_op_big ? w_op_exp : w_acc_exp)};
                end
                S_ADD: begin
                    r_sum  <= w_add_sum;
                    r_sign <= w_add_sign;
                end
                S_NORM: r_acc <= w_result;
                default: ;
            endcase
        end
    end

    assign acc_out = r_acc;
    assign count   = r_count;

endmodule
`default_nettype wire

// File: tb/tb_fp_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : tb_fp_accumulator
// Description : Directed self-checking bench for fp_accumulator.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_accumulator;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        clear;
    logic [31:0] acc_out;
    logic        acc_valid;
    logic        busy;
    logic [15:0] count;

    int errors = 0;
    int checks = 0;

    fp_accumulator #(.ACC_INIT(32'h0000_0000)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .clear     (clear),
        .acc_out   (acc_out),
        .acc_valid (acc_valid),
        .busy      (busy),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Every task starts and ends just after a falling edge.
    task automatic do_op(input logic [31:0] d, input string name);
        int waited = 0;
        while (!in_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s ready_timeout: in_ready=%b required 1", name, in_ready);
            return;
        end
        in_data  = d;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            if (k > 1) @(negedge clk);
            checks++;
            if (acc_valid !== 1'(k == 4)) begin
                errors++;
                $display("FAIL %s acc_valid_cycle%0d: got %b required %b", name, k, acc_valid, k == 4);
            end
            if (k == 2) begin
                checks++;
                if (busy !== 1'b1) begin
                    errors++;
                    $display("FAIL %s busy: got %b required 1", name, busy);
                end
            end
            if (k == 5) begin
                checks++;
                if (in_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL %s in_ready_return: got %b required 1", name, in_ready);
                end
            end
        end
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (acc_out !== 32'h0 || acc_valid !== 1'b0 || count !== 16'd0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: acc=%h valid=%b count=%0d ready=%b busy=%b required 00000000 0 0 1 0",
                     acc_out, acc_valid, count, in_ready, busy);
        end
    endtask

    task automatic test_accumulate();
        do_op(32'h3F800000, "acc_one");
        checks++;
        if (acc_out !== 32'h3F800000) begin
            errors++;
            $display("FAIL acc_one: got %h required 3f800000", acc_out);
        end
        do_op(32'h40000000, "acc_two");
        checks++;
        if (acc_out !== 32'h40400000 || count !== 16'd2) begin
            errors++;
            $display("FAIL acc_sum: acc=%h count=%0d required 40400000 2", acc_out, count);
        end
    endtask

    task automatic test_cancel();
        do_op(32'hC0400000, "cancel");
        checks++;
        if (acc_out !== 32'h00000000 || count !== 16'd3) begin
            errors++;
            $display("FAIL cancel_zero: acc=%h count=%0d required 00000000 3", acc_out, count);
        end
    endtask

    task automatic test_subtract_norm();
        do_clear();
        do_op(32'h40400000, "sub_a");
        do_op(32'hC0200000, "sub_b");
        checks++;
        if (acc_out !== 32'h3F000000) begin
            errors++;
            $display("FAIL sub_norm: got %h required 3f000000", acc_out);
        end
    endtask

    task automatic test_tiny();
        do_clear();
        do_op(32'h3F800000, "tiny_a");
        do_op(32'h30800000, "tiny_b");
        checks++;
        if (acc_out !== 32'h3F800000) begin
            errors++;
            $display("FAIL tiny_absorb: got %h required 3f800000", acc_out);
        end
    endtask

    task automatic test_denormal();
        do_clear();
        do_op(32'h00800000, "den_a");
        do_op(32'h80400000, "den_b");
        checks++;
        if (acc_out !== 32'h00400000) begin
            errors++;
            $display("FAIL denormal: got %h required 00400000", acc_out);
        end
    endtask

    task automatic test_overflow();
        logic [31:0] exp_val;
`ifdef FP_ACC_SATURATE_EN
        exp_val = 32'h7F7FFFFF;
`else
        exp_val = 32'h7F800000;
`endif
        do_clear();
        do_op(32'h7F7FFFFF, "ovf_a");
        do_op(32'h7F7FFFFF, "ovf_b");
        checks++;
        if (acc_out !== exp_val) begin
            errors++;
            $display("FAIL overflow: got %h required %h", acc_out, exp_val);
        end
    endtask

    task automatic test_clear_in_add();
        int pulses = 0;
        do_clear();
        do_op(32'h3F800000, "clr_pre");
        in_data  = 32'h40000000;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        checks++;
        if (acc_out !== 32'h0 || count !== 16'd0 || in_ready !== 1'b1 || busy !== 1'b0 || acc_valid !== 1'b0) begin
            errors++;
            $display("FAIL clear_in_add: acc=%h count=%0d ready=%b busy=%b valid=%b required 00000000 0 1 0 0",
                     acc_out, count, in_ready, busy, acc_valid);
        end
        repeat (4) begin
            @(negedge clk);
            if (acc_valid) pulses++;
        end
        checks++;
        if (pulses != 0 || acc_out !== 32'h0) begin
            errors++;
            $display("FAIL clear_no_pulse: pulses=%0d acc=%h required 0 00000000", pulses, acc_out);
        end
    endtask

    task automatic test_clear_vs_accept();
        do_op(32'h40000000, "cva_pre");
        in_data  = 32'h3F800000;
        in_valid = 1'b1;
        clear    = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        clear    = 1'b0;
        checks++;
        if (count !== 16'd0 || acc_out !== 32'h0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL clear_priority: count=%0d acc=%h ready=%b busy=%b required 0 00000000 1 0",
                     count, acc_out, in_ready, busy);
        end
    endtask

    task automatic test_reset_mid();
        int pulses = 0;
        do_op(32'h3F800000, "rm_pre");
        in_data  = 32'h40000000;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (acc_out !== 32'h0 || count !== 16'd0 || in_ready !== 1'b1 || busy !== 1'b0 || acc_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: acc=%h count=%0d ready=%b busy=%b valid=%b required 00000000 0 1 0 0",
                     acc_out, count, in_ready, busy, acc_valid);
        end
        repeat (4) begin
            @(negedge clk);
            if (acc_valid) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL reset_mid_pulse: pulses=%0d required 0", pulses);
        end
    endtask

    task automatic test_back_to_back();
        int waited = 0;
        do_clear();
        in_data  = 32'h3F800000;
        in_valid = 1'b1;
        repeat (11) @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (count !== 16'd3 || busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_count: count=%0d busy=%b required 3 1", count, busy);
        end
        while (!acc_valid && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (acc_valid !== 1'b1 || acc_out !== 32'h40400000) begin
            errors++;
            $display("FAIL b2b_sum: valid=%b acc=%h required 1 40400000", acc_valid, acc_out);
        end
    endtask

    initial begin
        rst      = 1'b1;
        clear    = 1'b0;
        in_valid = 1'b0;
        in_data  = 32'h0;
        @(negedge clk);
        test_reset();
        test_accumulate();
        test_cancel();
        test_subtract_norm();
        test_tiny();
        test_denormal();
        test_overflow();
        test_clear_in_add();
        test_clear_vs_accept();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fp_accumulator.md
FP_ACCUMULATOR -- requirements
Module: fp_accumulator

Interface
REQ-001 SHALL have parameter: ACC_INIT, 32'h0000_0000, single-precision value loaded into the accumulator on reset and on clear.
REQ-002 SHALL have port: clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port: rst  input  1  reset; synchronous, active-high.
REQ-004 SHALL have port: in_valid  input  1  in_data holds a product from the multiplier stage.
REQ-005 SHALL have port: in_ready  output  1  block can accept an operand this cycle.
REQ-006 SHALL have port: in_data  input  32  IEEE-754 single operand (sign, 8-bit exponent, 23-bit fraction).
REQ-007 SHALL have port: clear  input  1  synchronous accumulator clear request.
REQ-008 SHALL have port: acc_out  output  32  current accumulated sum, registered.
REQ-009 SHALL have port: acc_valid  output  1  one-cycle pulse; acc_out just updated.
REQ-010 SHALL have port: busy  output  1  high in any state other than IDLE.
REQ-011 SHALL have port: count  output  16  number of operands accepted since last reset/clear.

Function
REQ-012 SHALL implement FSM states IDLE, ALIGN, ADD, NORM, DONE; transitions IDLE->ALIGN on accept, ALIGN->ADD->NORM->DONE unconditionally, DONE->IDLE.
REQ-013 SHALL drive in_ready=1 only in IDLE; accept = in_valid & in_ready at a rising edge; in_data captured at that edge.
REQ-014 SHALL decode operands: exponent 0 -> effective exponent 1, hidden bit 0; else hidden bit 1.
REQ-015 ALIGN SHALL shift the smaller-exponent 24-bit mantissa right by the exponent difference with 3 guard bits; difference >= 27 yields zero magnitude.
REQ-016 ADD SHALL add magnitudes when signs equal, else subtract smaller from larger, result sign = sign of larger magnitude; exact zero result gives sign 0.
REQ-017 NORM SHALL on carry-out shift right 1 and increment exponent; otherwise left-shift by leading-zero count in one cycle, limited so exponent does not drop below 1; if hidden bit still 0, store exponent 0 (denormal).
REQ-018 SHALL truncate guard bits (round toward zero), matching the multiplier's truncation.
REQ-019 SHALL write acc_out at the NORM->DONE edge; acc_valid=1 for exactly the DONE cycle; first acc_valid 4 cycles after accept edge; in_ready returns 5 cycles after accept edge.
REQ-020 SHALL increment count at each accept, wrapping 16'hFFFF->16'h0000.
REQ-021 clear SHALL have priority over accept: when clear=1 in any state, next cycle acc_out=ACC_INIT, count=0, state=IDLE, acc_valid=0, in-flight operand discarded, no in_data captured that edge.
REQ-022 NaN/infinity inputs SHALL be processed as ordinary values (no special-case detection).

Reset
REQ-023 On rst=1 at a clock edge: state=IDLE, acc_out=ACC_INIT, acc_valid=0, busy=0, count=0, in_ready=1 the following cycle; rst overrides clear and in_valid.
REQ-024 Reset mid-operation SHALL discard the in-flight operand with no acc_valid pulse.

Configuration
REQ-025 Macro FP_ACC_SATURATE_EN: when defined, exponent overflow (>=255 after NORM) SHALL store {sign, 8'hFE, 23'h7FFFFF}; when undefined, SHALL store {sign, 8'hFF, 23'h0} (infinity).

Verification
REQ-026 Reset, then idle 3 cycles -> acc_out=0x00000000, acc_valid=0, count=0, in_ready=1.
REQ-027 Accept 0x3F800000 then 0x40000000 -> acc_valid pulses 4 cycles after each accept; final acc_out=0x40400000, count=2.
REQ-028 acc=0x40400000, accept 0xC0400000 -> acc_out=0x00000000 (positive zero).
REQ-029 acc=0x3F800000, accept 0x30800000 (2^-30) -> acc_out stays 0x3F800000.
REQ-030 Assert clear in ADD state -> next cycle acc_out=ACC_INIT, count=0, state IDLE, no acc_valid pulse.
REQ-031 acc=0x7F7FFFFF, accept 0x7F7FFFFF -> acc_out=0x7F7FFFFF with FP_ACC_SATURATE_EN, 0x7F800000 without.
